// File: rtl/feature_vector_serializer.sv
// Accepts a full parallel feature vector on a one-cycle valid pulse and streams it
// one feature per cycle over a valid/ready handshake, counting vectors dropped while busy.
module feature_vector_serializer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FEATURES = 1280,
    parameter int unsigned IDX_W    = $clog2(FEATURES),
    parameter int unsigned DROP_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] data_in [0:FEATURES-1],
    input  logic                    valid_in,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic [IDX_W-1:0]        m_index,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_count
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FEATURES - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [DROP_W-1:0]       drop_q, drop_d;
    logic                    load_c;
    logic signed [WIDTH-1:0] vec_q [0:FEATURES-1];

    // State, index and drop counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            index_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            drop_q  <= drop_d;
        end
    end

    // Vector buffer holds its contents across reset; written only on acceptance
    always_ff @(posedge clk) begin
        if (load_c) begin
            vec_q <= data_in;
        end
    end

    // Next-state: acceptance in IDLE, streaming with backpressure and drop counting
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        drop_d  = drop_q;
        load_c  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        load_c  = 1'b1;
                        index_d = '0;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (valid_in && (drop_q != DROP_MAX)) begin
                        drop_d = drop_q + DROP_W'(1);
                    end
                    if (m_ready) begin
                        if (index_q == LAST_IDX) begin
                            index_d = '0;
                            state_d = IDLE;
                        end else begin
                            index_d = index_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // m_valid follows en so a disabled block can never complete a transfer
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == STREAM);
    assign m_valid    = busy && en;
    assign m_data     = vec_q[index_q];
    assign m_index    = index_q;
    assign m_last     = m_valid && (index_q == LAST_IDX);
    assign drop_count = drop_q;

endmodule
